// File: rtl/mwc_pkg.sv
// Shared types and constants for the memory write checker.
package mwc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_e;

   localparam logic [1:0] FC_NONE       = 2'd0;
   localparam logic [1:0] FC_MISMATCH   = 2'd1;
   localparam logic [1:0] FC_TIMEOUT    = 2'd2;
   localparam logic [1:0] FC_INCOMPLETE = 2'd3;

   // Index width that stays legal for a single-entry table.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mwc_match.sv
// Address comparators over the expected table with lowest-index priority.
module mwc_match #(
   parameter int unsigned NUM_CHECKS = 4,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned IDX_W      = 2
) (
   input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
   input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
   input  logic [NUM_CHECKS-1:0]        cand,
   input  logic [ADDR_W-1:0]            adr,
   input  logic [DATA_W-1:0]            writedata,
   output logic                         match_valid,
   output logic [IDX_W-1:0]             match_idx,
   output logic                         data_ok
);

   // First candidate entry whose address matches wins; data checked against it only.
   always_comb begin
      match_valid = 1'b0;
      match_idx   = '0;
      data_ok     = 1'b0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
         if (!match_valid && cand[i] && (exp_addr[i*ADDR_W +: ADDR_W] == adr)) begin
            match_valid = 1'b1;
            match_idx   = IDX_W'(i);
            data_ok     = (exp_data[i*DATA_W +: DATA_W] == writedata);
         end
      end
   end

endmodule

// File: rtl/mem_write_checker.sv
// Snoops data-memory stores, checks them against an expected table and latches a verdict.
module mem_write_checker
   import mwc_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       NUM_CHECKS = 4,
   parameter int unsigned       TIMEOUT    = 1000,
   parameter logic [ADDR_W-1:0] TERM_ADDR  = ADDR_W'(32'hFC)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           ordered,
   input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
   input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
   input  logic [ADDR_W-1:0]              adr,
   input  logic [DATA_W-1:0]              writedata,
   input  logic                           memwrite,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic [1:0]                     fail_code,
   output logic [$clog2(NUM_CHECKS+1)-1:0] hits,
   output logic [31:0]                    cycles
);

   localparam int unsigned      HIT_W    = $clog2(NUM_CHECKS + 1);
   localparam int unsigned      IDX_W    = idx_width(NUM_CHECKS);
   localparam int unsigned      CYC_W    = 32;
   localparam logic [HIT_W-1:0] HITS_ALL = HIT_W'(NUM_CHECKS);
   localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(TIMEOUT - 1);

   state_e                 state_q, state_d;
   logic [NUM_CHECKS-1:0]  mask_q, mask_d;
   logic [HIT_W-1:0]       hits_q, hits_d;
   logic [CYC_W-1:0]       cycles_q, cycles_d;
   logic [1:0]             fc_q, fc_d;
   logic                   ord_q, ord_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;

   logic [NUM_CHECKS-1:0]  cand;
   logic                   match_valid;
   logic [IDX_W-1:0]       match_idx;
   logic                   data_ok;

   // Eligible entries: in ordered mode only the next one (hit count doubles as index), else all un-hit.
   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
         cand[i] = ord_q ? (hits_q == HIT_W'(i)) : !mask_q[i];
      end
   end

   mwc_match #(
      .NUM_CHECKS (NUM_CHECKS),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .IDX_W      (IDX_W)
   ) u_match (
      .exp_addr    (exp_addr),
      .exp_data    (exp_data),
      .cand        (cand),
      .adr         (adr),
      .writedata   (writedata),
      .match_valid (match_valid),
      .match_idx   (match_idx),
      .data_ok     (data_ok)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         hits_q   <= '0;
         cycles_q <= '0;
         fc_q     <= FC_NONE;
         ord_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         hits_q   <= hits_d;
         cycles_q <= cycles_d;
         fc_q     <= fc_d;
         ord_q    <= ord_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   // Next state: entry matches beat the terminator, any store decision beats the timeout.
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      hits_d   = hits_q;
      cycles_d = cycles_q;
      fc_d     = fc_q;
      ord_d    = ord_q;
      case (state_q)
         RUN: begin
            if (cycles_q != '1) begin
               cycles_d = cycles_q + CYC_W'(1);
            end
            if (memwrite && match_valid) begin
               if (data_ok) begin
                  mask_d[match_idx] = 1'b1;
                  hits_d            = hits_q + HIT_W'(1);
                  if (hits_d == HITS_ALL) begin
                     state_d = PASS;
                  end
               end else begin
                  state_d = FAIL;
                  fc_d    = FC_MISMATCH;
               end
            end else if (memwrite && (adr == TERM_ADDR)) begin
               if (hits_q == HITS_ALL) begin
                  state_d = PASS;
               end else begin
                  state_d = FAIL;
                  fc_d    = FC_INCOMPLETE;
               end
            end
            if ((state_d == RUN) && (TIMEOUT != 0) && (cycles_q == TO_LAST)) begin
               state_d = FAIL;
               fc_d    = FC_TIMEOUT;
            end
         end
         default: begin
            if (start) begin
               state_d  = RUN;
               mask_d   = '0;
               hits_d   = '0;
               cycles_d = '0;
               fc_d     = FC_NONE;
               ord_d    = ordered;
            end
         end
      endcase
   end

   // Status flags decoded from the next state so they register alongside it.
   always_comb begin
      busy_d = (state_d == RUN);
      done_d = (state_d == PASS) || (state_d == FAIL);
      pass_d = (state_d == PASS);
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_code = fc_q;
   assign hits      = hits_q;
   assign cycles    = cycles_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: directed scenarios plus randomized runs.
module tb_mem_write_checker;

   localparam int          N    = 4;
   localparam int          T    = 20;
   localparam logic [31:0] TERM = 32'hFC;

   typedef struct packed {
      logic        pass;
      logic [1:0]  fc;
      logic [2:0]  hits;
      logic [31:0] cycles;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, start, ordered, memwrite;
   logic [31:0]   adr, writedata;
   logic [N*32-1:0] exp_addr, exp_data;
   logic          busy, done, pass;
   logic [1:0]    fail_code;
   logic [2:0]    hits;
   logic [31:0]   cycles;

   logic [31:0]   tbl_a [N];
   logic [31:0]   tbl_d [N];
   bit            st_we [T];
   logic [31:0]   st_a  [T];
   logic [31:0]   st_d  [T];

   exp_t          exp_q [$];
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign exp_addr[g*32 +: 32] = tbl_a[g];
      assign exp_data[g*32 +: 32] = tbl_d[g];
   end

   mem_write_checker #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .NUM_CHECKS (N),
      .TIMEOUT    (T),
      .TERM_ADDR  (TERM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ordered   (ordered),
      .exp_addr  (exp_addr),
      .exp_data  (exp_data),
      .adr       (adr),
      .writedata (writedata),
      .memwrite  (memwrite),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_code (fail_code),
      .hits      (hits),
      .cycles    (cycles)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Reference: walk the per-cycle store list applying the checker rules; dec = deciding RUN cycle.
   function automatic void model(input bit ord, output exp_t e, output int dec);
      bit hit [N];
      int nh, sel;
      bit decided;
      nh = 0; decided = 0; dec = T - 1;
      e = '0;
      for (int i = 0; i < N; i++) hit[i] = 0;
      for (int k = 0; k < T && !decided; k++) begin
         if (st_we[k]) begin
            sel = -1;
            if (ord) begin
               if (st_a[k] == tbl_a[nh]) sel = nh;
            end else begin
               for (int i = N - 1; i >= 0; i--)
                  if (!hit[i] && st_a[k] == tbl_a[i]) sel = i;
            end
            if (sel >= 0) begin
               if (st_d[k] != tbl_d[sel]) begin
                  e.pass = 1'b0; e.fc = 2'd1; e.hits = 3'(nh); e.cycles = 32'(k + 1);
                  decided = 1;
               end else begin
                  hit[sel] = 1;
                  nh++;
                  if (nh == N) begin
                     e.pass = 1'b1; e.fc = 2'd0; e.hits = 3'(nh); e.cycles = 32'(k + 1);
                     decided = 1;
                  end
               end
            end else if (st_a[k] == TERM) begin
               e.pass = (nh == N); e.fc = (nh == N) ? 2'd0 : 2'd3;
               e.hits = 3'(nh); e.cycles = 32'(k + 1);
               decided = 1;
            end
         end
         if (!decided && k == T - 1) begin
            e.pass = 1'b0; e.fc = 2'd2; e.hits = 3'(nh); e.cycles = 32'(T);
            decided = 1;
         end
         if (decided) dec = k;
      end
   endfunction

   task automatic clear_stim();
      for (int k = 0; k < T; k++) begin
         st_we[k] = 0; st_a[k] = '0; st_d[k] = '0;
      end
   endtask

   task automatic put(input int k, input logic [31:0] a, input logic [31:0] d);
      st_we[k] = 1; st_a[k] = a; st_d[k] = d;
   endtask

   task automatic set_tbl(input int i, input logic [31:0] a, input logic [31:0] d);
      tbl_a[i] = a; tbl_d[i] = d;
   endtask

   // One complete run: push expectation, start, replay T cycles of stores, then check verdict hold.
   task automatic do_run(input bit ord);
      exp_t e;
      int   dec, sp;
      model(ord, e, dec);
      exp_q.push_back(e);
      sp = (dec > 0) ? int'($urandom_range(0, dec - 1)) : -1;
      @(posedge clk); #1;
      start = 1'b1; ordered = ord; memwrite = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_in_run", 32'(busy), 32'd1);
      for (int k = 0; k < T; k++) begin
         memwrite  = st_we[k];
         adr       = st_we[k] ? st_a[k] : 32'($urandom);
         writedata = st_we[k] ? st_d[k] : 32'($urandom);
         start     = (k == sp);
         ordered   = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      memwrite = 1'b0; start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("verdict_seen", 32'(exp_q.size()), 32'd0);
      chk("done_hold", 32'(done), 32'd1);
      chk("pass_hold", 32'(pass), 32'(e.pass));
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   // Monitor: on each rising verdict, pop the scoreboard and compare.
   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1 && prev !== 1'b1) begin
            chk("verdict_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("pass", 32'(pass), 32'(e.pass));
               chk("fail_code", 32'(fail_code), 32'(e.fc));
               chk("hits", 32'(hits), 32'(e.hits));
               chk("cycles", cycles, e.cycles);
               chk("busy_at_verdict", 32'(busy), 32'd0);
            end
         end
         prev = done;
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_fail_code"}, 32'(fail_code), 32'd0);
      chk({tag, "_hits"}, 32'(hits), 32'd0);
      chk({tag, "_cycles"}, cycles, 32'd0);
   endtask

   task automatic tbl_unordered();
      set_tbl(0, 32'h10, 1); set_tbl(1, 32'h20, 2); set_tbl(2, 32'h20, 3); set_tbl(3, 32'h30, 4);
   endtask

   initial begin
      int r, j;
      reset = 1'b1; start = 1'b0; ordered = 1'b0; memwrite = 1'b0;
      adr = '0; writedata = '0;
      for (int i = 0; i < N; i++) set_tbl(i, 32'h0, 32'h0);
      clear_stim();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");

      // Ordered, last store at cycle 7.
      set_tbl(0, 32'h4C, 5); set_tbl(1, 32'h50, 6); set_tbl(2, 32'h54, 7); set_tbl(3, 32'h58, 8);
      clear_stim(); put(1, 32'h4C, 5); put(3, 32'h50, 6); put(5, 32'h54, 7); put(7, 32'h58, 8);
      do_run(1);

      // Ordered: out-of-order store ignored, then data mismatch on the current entry.
      set_tbl(0, 32'h10, 1); set_tbl(1, 32'h20, 2); set_tbl(2, 32'h30, 3); set_tbl(3, 32'h40, 4);
      clear_stim(); put(0, 32'h20, 2); put(1, 32'h10, 1); put(2, 32'h20, 2);
      put(3, 32'h10, 7); put(4, 32'h30, 9);
      do_run(1);
      clear_stim(); put(0, 32'h10, 7);
      do_run(1);

      // Unordered with duplicate addresses: pass, and lowest-index mismatch.
      tbl_unordered();
      clear_stim(); put(0, 32'h20, 2); put(1, 32'h10, 1); put(2, 32'h20, 3); put(3, 32'h30, 4);
      do_run(0);
      clear_stim(); put(0, 32'h20, 3);
      do_run(0);

      // Timeout, and a final store on the last cycle beating it.
      clear_stim();
      do_run(1);
      clear_stim(); put(0, 32'h20, 2); put(1, 32'h10, 1); put(2, 32'h30, 4); put(19, 32'h20, 3);
      do_run(0);

      // Terminator after 2 hits, and after the pass already happened.
      clear_stim(); put(0, 32'h10, 1); put(2, 32'h30, 4); put(5, TERM, 0);
      do_run(0);
      clear_stim(); put(0, 32'h20, 2); put(1, 32'h10, 1); put(2, 32'h20, 3); put(3, 32'h30, 4);
      put(4, TERM, 0);
      do_run(0);

      // Entry at the terminator address is consumed as a match first.
      set_tbl(0, TERM, 9); set_tbl(1, 32'h10, 1); set_tbl(2, 32'h20, 2); set_tbl(3, 32'h30, 3);
      clear_stim(); put(0, TERM, 9); put(1, TERM, 0);
      do_run(1);

      // Reset mid-run after one hit aborts with no verdict; stores in IDLE are ignored.
      set_tbl(0, 32'h4C, 5); set_tbl(1, 32'h50, 6); set_tbl(2, 32'h54, 7); set_tbl(3, 32'h58, 8);
      @(posedge clk); #1 start = 1'b1; ordered = 1'b1;
      @(posedge clk); #1 start = 1'b0; memwrite = 1'b1; adr = 32'h4C; writedata = 5;
      @(posedge clk); #1 memwrite = 1'b0;
      chk("hits_before_reset", 32'(hits), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk_all_zero("abort");
      memwrite = 1'b1; adr = TERM;
      repeat (2) @(posedge clk);
      #1 memwrite = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      clear_stim(); put(1, 32'h4C, 5); put(3, 32'h50, 6); put(5, 32'h54, 7); put(7, 32'h58, 8);
      do_run(1);

      // Randomized runs.
      for (int run = 0; run < 60; run++) begin
         for (int i = 0; i < N; i++)
            set_tbl(i, 32'h10 * 32'($urandom_range(1, 4)), 32'($urandom_range(0, 3)));
         clear_stim();
         for (int k = 0; k < T; k++) begin
            if ($urandom_range(0, 99) < 45) begin
               r = int'($urandom_range(0, 19));
               if (r == 0) put(k, TERM, 32'($urandom));
               else if (r == 1) put(k, 32'h80, 32'($urandom));
               else begin
                  j = int'($urandom_range(0, N - 1));
                  put(k, tbl_a[j], ($urandom_range(0, 9) == 0) ? (tbl_d[j] ^ 32'd1) : tbl_d[j]);
               end
            end
         end
         do_run(1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor that replaces hard-coded "address X, data Y" success checks in processor testbenches.
- Snoops the data-memory write bus of the processor top (adr, writedata, memwrite) and compares stores against a table of NUM_CHECKS expected (address, data) pairs.
- Enforces a cycle timeout.
- Latches a pass/fail verdict with a failure code, readable by the bench or by on-chip status logic.

Parameters:
- ADDR_W, 32, width of snooped address
- DATA_W, 32, width of snooped write data
- NUM_CHECKS, 4, number of expected (address, data) entries; must be >= 1
- TIMEOUT, 1000, cycles in RUN before a timeout failure; 0 disables the timeout
- TERM_ADDR, 32'hFC, store address that ends the check early

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; forces IDLE and clears all state
- start  in  1  one-cycle pulse; IDLE/PASS/FAIL -> RUN
- ordered  in  1  1 = entries must be satisfied in index order; 0 = any order; sampled on start
- exp_addr  in  NUM_CHECKS*ADDR_W  packed expected addresses, entry i at [i*ADDR_W +: ADDR_W]; must be stable during RUN
- exp_data  in  NUM_CHECKS*DATA_W  packed expected data, same packing rule
- adr  in  ADDR_W  snooped memory address
- writedata  in  DATA_W  snooped store data
- memwrite  in  1  store strobe; a store is any cycle with memwrite=1
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS only
- fail_code  out  2  0 none, 1 MISMATCH, 2 TIMEOUT, 3 INCOMPLETE
- hits  out  $clog2(NUM_CHECKS+1)  number of entries satisfied
- cycles  out  32  RUN cycle count, saturating at 2^32-1

Behaviour:
- Reset values: all outputs 0; state IDLE; hit mask and entry index 0; ordered latch 0.
- FSM states: IDLE, RUN, PASS, FAIL. All outputs are registered.
- start in IDLE/PASS/FAIL: go to RUN next cycle; clear hits, mask, index, cycles and fail_code; latch ordered. start during RUN is ignored.
- RUN: cycles increments each cycle, including the deciding cycle.
- Ordered mode, store with adr == exp_addr[idx]:
  - writedata equal: idx++, hits++.
  - writedata unequal: FAIL, MISMATCH.
  - Stores to other addresses are ignored, except TERM_ADDR.
- Unordered mode, store whose adr matches one or more un-hit entries:
  - The lowest-index un-hit match is selected.
  - Data equal: set its mask bit, hits++. Data unequal: FAIL, MISMATCH.
  - Stores to already-hit addresses are ignored.
- Satisfying the last entry (hits reaches NUM_CHECKS): PASS.
- Store to TERM_ADDR that is not consumed as an expected-entry match: PASS if all entries are hit, otherwise FAIL with INCOMPLETE. Expected-entry matching has priority over the terminator.
- Timeout: if TIMEOUT != 0 and cycles reaches TIMEOUT-1 with no decision, FAIL with TIMEOUT. A deciding store in the same cycle wins over the timeout.
- Latency: the verdict appears on done/pass/fail_code one cycle after the deciding store edge. It holds until the next start or reset.
- memwrite is ignored outside RUN. reset mid-RUN aborts with no verdict (done=0).
- Equality comparisons are full-width and exact. No X-propagation handling is required.

Decomposition:
- Shared package mwc_pkg holds:
  - the state enum (IDLE/RUN/PASS/FAIL);
  - fail-code constants FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_INCOMPLETE.
- One sub-module, mwc_match: combinational, NUM_CHECKS-wide address comparators with lowest-index priority select. Outputs are match_valid, match_idx and data_ok.

Test Plan:
- Ordered, NUM_CHECKS=1, entry (0x4C, 5): start, then store 0x4C=5 at cycle 7 -> done=1, pass=1, fail_code=0, hits=1, cycles=8.
- Ordered, entries (0x10,1) and (0x20,2): stores 0x20=2 then 0x10=1 -> hits=1; then store 0x20=2 -> PASS. Store 0x10=7 in place of 0x10=1 -> FAIL, fail_code=1.
- Unordered, entries (0x10,1), (0x20,2), (0x20,3): stores 0x20=2, 0x10=1, 0x20=3 -> PASS, hits=3. A store 0x20=3 arriving first -> FAIL, MISMATCH.
- TIMEOUT=20, no matching stores -> FAIL, fail_code=2, done rises 20 cycles after RUN entry. Final matching store on cycle 19 -> PASS instead.
- TERM_ADDR store after 2 of 4 hits -> FAIL, fail_code=3, hits=2. After 4 of 4 hits, the PASS has already occurred and the TERM_ADDR store is ignored.
- Reset asserted mid-RUN after 1 hit -> all outputs 0 next cycle. A new start runs cleanly to PASS. start pulsed during RUN has no effect.
